lcd_spi_panel_driver: RTL and testbench
=======================================

# lcd_spi_panel_driver

Parametrised 4-wire SPI driver for ST7789-class TFT panels, sized per panel by parameter. It performs power-up delay, hardware reset and an init command sequence with per-command delays. Afterwards it streams RGB565 pixel frames from an upstream valid/ready source into panel RAM, one full window per frame, indefinitely. It sits between the frame/pattern generator and the LCD pins.

## Interface
- CLK_DIV, 2: clk cycles per SCL half-period; legal range ≥1.
- DISP_W, 135: window width in pixels.
- DISP_H, 240: window height in pixels.
- COL_OFS, 52: first panel column of the window.
- ROW_OFS, 40: first panel row of the window.
- START_DLY, 2700000: clk cycles before hardware reset.
- HWRST_DLY, 270: clk cycles lcd_rst is held low.
- LONG_DLY, 2700000: long post-command delay, in clk cycles.
- SHORT_DLY, 135000: short post-command delay, in clk cycles.
- INVERT, 1: 1 sends INVON (0x21) in the init sequence, 0 sends INVOFF (0x20).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pix_data  in  16  RGB565 pixel, sent MSB first
- pix_valid  in  1  pixel available
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- frame_start  out  1  one-cycle pulse when the first pixel of a frame is accepted
- init_done  out  1  high from the end of the init sequence onward
- lcd_rst  out  1  panel reset, active-low
- lcd_rs  out  1  0 = command byte, 1 = data byte
- lcd_sd  out  1  serial data
- lcd_scl  out  1  serial clock
- lcd_cs  out  1  chip select, active-low

## Operation
- Reset values:
  - lcd_rst=1, lcd_cs=1, lcd_scl=0, lcd_sd=0, lcd_rs=1.
  - pix_ready=0, frame_start=0, init_done=0.
  - All counters are 0 and the FSM is in START.
- FSM: START → HWRST → POSTRST → INIT → WINDOW → STREAM → WINDOW → …
  - START: wait START_DLY cycles.
  - HWRST: lcd_rst=0 for HWRST_DLY cycles.
  - POSTRST: wait LONG_DLY cycles.
  - INIT: walk the init ROM in order, as command(arguments)/delay:
    - SWRESET 0x01 / LONG
    - SLPOUT 0x11 / LONG
    - COLMOD 0x3A(0x55) / SHORT
    - MADCTL 0x36(0x00) / none
    - INVON 0x21 or INVOFF 0x20 / SHORT
    - NORON 0x13 / SHORT
    - DISPON 0x29 / LONG
    - After the last delay, init_done=1.
  - WINDOW: send, each as its own transaction:
    - CASET 0x2A with {COL_OFS[15:8], COL_OFS[7:0], CE[15:8], CE[7:0]}, CE = COL_OFS+DISP_W-1.
    - RASET 0x2B likewise with ROW_OFS and RE = ROW_OFS+DISP_H-1.
    - Then RAMWR 0x2C, which opens STREAM.
  - STREAM: accept exactly DISP_W*DISP_H pixels, each sent as 2 data bytes, high byte first. After the last pixel's low byte, raise lcd_cs and return to WINDOW.
- Transactions:
  - lcd_cs is low from the command byte through the last argument byte. For RAMWR it stays low through the last pixel byte.
  - lcd_rs=0 only during the command byte.
  - Between transactions lcd_cs is high for at least 2*CLK_DIV cycles.
  - A post-command delay counts from lcd_cs rising.
- Pixel buffer: one 16-bit entry.
  - pix_ready = (state==STREAM) && buffer empty.
  - The buffer empties when the serializer loads its high byte, so the next pixel can be accepted while the current one shifts.
- Underflow: if the buffer is empty at a byte boundary, SCL holds low and lcd_cs stays low until a pixel arrives. There is no timeout.
- All coordinate arithmetic is 16-bit. Pixel counter width is $clog2(DISP_W*DISP_H+1).

## Timing
- SPI mode 0: SCL idles low, MSB first.
  - lcd_sd and lcd_rs change only while SCL is low, CLK_DIV cycles before the rising edge.
  - The panel samples on the rising edge.
- One byte is 16*CLK_DIV clk cycles, with no gap between bytes inside a transaction.
- lcd_cs falls CLK_DIV cycles before the first SCL rise. It rises CLK_DIV cycles after the last SCL fall.
- The delay counters are exact: lcd_rst is low for exactly HWRST_DLY cycles.
- frame_start is asserted in the same cycle as the first pixel handshake of each frame.
- Asynchronous reset mid-transfer returns all outputs to their reset values immediately, and the driver restarts from START after release. No partial byte is completed.
- pix_valid with pix_ready low has no effect. The data is not sampled.

## Test plan
Bench parameters: CLK_DIV=2, DISP_W=4, DISP_H=2, COL_OFS=52, ROW_OFS=40, START_DLY=8, HWRST_DLY=4, LONG_DLY=20, SHORT_DLY=6.

- Power-up: release rst → lcd_rst stays high for 8 cycles, then goes low for exactly 4 cycles. lcd_cs stays high until 20 cycles later.
- Init decode: an SPI monitor captures the sequence 01; 11; 3A 55; 36 00; 21; 13; 29. rs=0 only on the first byte of each. cs-high gaps are ≥20 / 6 cycles per the table. init_done rises after DISPON plus 20 cycles.
- Window: the monitor captures 2A 00 34 00 37, then 2B 00 28 00 29, then 2C with cs held low.
- Stream: pix_valid held high with pixels 0xF800, 0x07E0, 0x001F, 0xFFFF, 0x0000, 0x1234, 0xABCD, 0x8001 → 16 data bytes in that order, high byte first, and a frame_start pulse at the first handshake. Then the next 2A transaction follows.
- Underflow: drop pix_valid for 50 cycles after pixel 3 → SCL is static low and cs stays low during the gap. Byte stream is intact after resumption.
- Reset mid-RAMWR: assert rst during pixel 5 → outputs show their reset values in the same cycle. After release the START delay is repeated.

Source files
------------

// File: rtl/lcd_spi_panel_driver.sv
// ST7789-class 4-wire SPI panel driver: power-up, reset, init ROM,
// then endless RGB565 window streaming from a valid/ready source.
module lcd_spi_panel_driver #(
    parameter int CLK_DIV   = 2,
    parameter int DISP_W    = 135,
    parameter int DISP_H    = 240,
    parameter int COL_OFS   = 52,
    parameter int ROW_OFS   = 40,
    parameter int START_DLY = 2700000,
    parameter int HWRST_DLY = 270,
    parameter int LONG_DLY  = 2700000,
    parameter int SHORT_DLY = 135000,
    parameter int INVERT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        init_done,
    output logic        lcd_rst,
    output logic        lcd_rs,
    output logic        lcd_sd,
    output logic        lcd_scl,
    output logic        lcd_cs
);

    localparam logic [2:0] S_START   = 3'd0;
    localparam logic [2:0] S_HWRST   = 3'd1;
    localparam logic [2:0] S_POSTRST = 3'd2;
    localparam logic [2:0] S_INIT    = 3'd3;
    localparam logic [2:0] S_WINDOW  = 3'd4;
    localparam logic [2:0] S_STREAM  = 3'd5;

    localparam logic [2:0] P_GAP  = 3'd0;
    localparam logic [2:0] P_LO   = 3'd1;
    localparam logic [2:0] P_HI   = 3'd2;
    localparam logic [2:0] P_WAIT = 3'd3;
    localparam logic [2:0] P_TAIL = 3'd4;

    localparam logic [1:0] G_N = 2'd0;
    localparam logic [1:0] G_S = 2'd1;
    localparam logic [1:0] G_L = 2'd2;

    localparam logic [4:0] IDX_WIN   = 5'd9;
    localparam logic [4:0] IDX_RAMWR = 5'd19;

    localparam int NPIX = DISP_W * DISP_H;
    localparam int PCW  = $clog2(NPIX + 1);
    localparam logic [PCW-1:0] NPIX_C = PCW'(NPIX);

    localparam int GN = 2 * CLK_DIV;
    localparam int GS = (SHORT_DLY > GN) ? SHORT_DLY : GN;
    localparam int GL = (LONG_DLY > GN) ? LONG_DLY : GN;

    localparam logic [31:0] START_M1 = 32'(START_DLY - 1);
    localparam logic [31:0] HWRST_M1 = 32'(HWRST_DLY - 1);
    localparam logic [31:0] LONG_M1  = 32'(LONG_DLY - 1);
    localparam logic [31:0] GN_M1    = 32'(GN - 1);
    localparam logic [31:0] GS_M1    = 32'(GS - 1);
    localparam logic [31:0] GL_M1    = 32'(GL - 1);
    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);

    localparam logic [15:0] CS_W = 16'(COL_OFS);
    localparam logic [15:0] CE_W = 16'(COL_OFS + DISP_W - 1);
    localparam logic [15:0] RS_W = 16'(ROW_OFS);
    localparam logic [15:0] RE_W = 16'(ROW_OFS + DISP_H - 1);
    localparam logic [7:0]  INV_CMD = (INVERT != 0) ? 8'h21 : 8'h20;

    // Bytes of the init sequence (0..8) followed by the window setup (9..19).
    function automatic logic [7:0] rom_byte(input logic [4:0] i);
        case (i)
            5'd0:    rom_byte = 8'h01;
            5'd1:    rom_byte = 8'h11;
            5'd2:    rom_byte = 8'h3A;
            5'd3:    rom_byte = 8'h55;
            5'd4:    rom_byte = 8'h36;
            5'd5:    rom_byte = 8'h00;
            5'd6:    rom_byte = INV_CMD;
            5'd7:    rom_byte = 8'h13;
            5'd8:    rom_byte = 8'h29;
            5'd9:    rom_byte = 8'h2A;
            5'd10:   rom_byte = CS_W[15:8];
            5'd11:   rom_byte = CS_W[7:0];
            5'd12:   rom_byte = CE_W[15:8];
            5'd13:   rom_byte = CE_W[7:0];
            5'd14:   rom_byte = 8'h2B;
            5'd15:   rom_byte = RS_W[15:8];
            5'd16:   rom_byte = RS_W[7:0];
            5'd17:   rom_byte = RE_W[15:8];
            5'd18:   rom_byte = RE_W[7:0];
            5'd19:   rom_byte = 8'h2C;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    // Per-byte control: {rs, last byte of transaction, post-delay select}.
    function automatic logic [3:0] rom_ctl(input logic [4:0] i);
        case (i)
            5'd0, 5'd1, 5'd8:         rom_ctl = {1'b0, 1'b1, G_L};
            5'd2, 5'd4, 5'd9, 5'd14:  rom_ctl = {1'b0, 1'b0, G_N};
            5'd3:                     rom_ctl = {1'b1, 1'b1, G_S};
            5'd5, 5'd13, 5'd18:       rom_ctl = {1'b1, 1'b1, G_N};
            5'd6, 5'd7:               rom_ctl = {1'b0, 1'b1, G_S};
            5'd19:                    rom_ctl = {1'b0, 1'b1, G_N};
            default:                  rom_ctl = {1'b1, 1'b0, G_N};
        endcase
    endfunction

    logic [2:0]     state_q, state_d;
    logic [2:0]     ph_q, ph_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [15:0]    div_q, div_d;
    logic [2:0]     bitn_q, bitn_d;
    logic [7:0]     sh_q, sh_d;
    logic [4:0]     idx_q, idx_d;
    logic [1:0]     gsel_q, gsel_d;
    logic [15:0]    pbuf_q, pbuf_d;
    logic           pfull_q, pfull_d;
    logic [7:0]     lo_q, lo_d;
    logic           lopend_q, lopend_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           scl_q, scl_d;
    logic           cs_q, cs_d;
    logic           sd_q, sd_d;
    logic           rs_q, rs_d;
    logic           lrst_q, lrst_d;
    logic           idone_q, idone_d;

    logic           hs;
    logic [3:0]     ctl;
    logic [31:0]    gap_m1;
    logic           start;
    logic           byte_end;
    logic           take_pix;
    logic           ld;
    logic [7:0]     ld_byte;
    logic           ld_rs;

    // Pixel handshake: one-entry buffer, closed once the frame is fully taken.
    assign pix_ready   = (state_q == S_STREAM) && !pfull_q && (pcnt_q != NPIX_C);
    assign hs          = pix_valid && pix_ready;
    assign frame_start = hs && (pcnt_q == '0);

    assign init_done = idone_q;
    assign lcd_rst   = lrst_q;
    assign lcd_rs    = rs_q;
    assign lcd_sd    = sd_q;
    assign lcd_scl   = scl_q;
    assign lcd_cs    = cs_q;

    // Sequencer, SPI bit engine and pixel buffer next-state logic.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bitn_d   = bitn_q;
        sh_d     = sh_q;
        idx_d    = idx_q;
        gsel_d   = gsel_q;
        pbuf_d   = pbuf_q;
        pfull_d  = pfull_q;
        lo_d     = lo_q;
        lopend_d = lopend_q;
        pcnt_d   = pcnt_q;
        scl_d    = scl_q;
        cs_d     = cs_q;
        sd_d     = sd_q;
        rs_d     = rs_q;
        lrst_d   = lrst_q;
        idone_d  = idone_q;
        start    = 1'b0;
        byte_end = 1'b0;
        take_pix = 1'b0;
        ld       = 1'b0;
        ld_byte  = 8'h00;
        ld_rs    = 1'b1;
        ctl      = rom_ctl(idx_q);

        case (gsel_q)
            G_S:     gap_m1 = GS_M1;
            G_L:     gap_m1 = GL_M1;
            default: gap_m1 = GN_M1;
        endcase

        if (hs) begin
            pbuf_d  = pix_data;
            pfull_d = 1'b1;
            pcnt_d  = pcnt_q + PCW'(1);
        end

        case (state_q)
            S_START: begin
                if (cnt_q == START_M1) begin
                    cnt_d   = '0;
                    state_d = S_HWRST;
                    lrst_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HWRST: begin
                if (cnt_q == HWRST_M1) begin
                    cnt_d   = '0;
                    state_d = S_POSTRST;
                    lrst_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_POSTRST: begin
                if (cnt_q == LONG_M1) begin
                    cnt_d   = '0;
                    state_d = S_INIT;
                    start   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                case (ph_q)
                    P_GAP: begin
                        if (cnt_q == gap_m1) begin
                            cnt_d = '0;
                            start = 1'b1;
                            if (state_q == S_INIT && idx_q == IDX_WIN) begin
                                idone_d = 1'b1;
                                state_d = S_WINDOW;
                            end
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    P_LO: begin
                        if (div_q == DIV_M1) begin
                            div_d = '0;
                            scl_d = 1'b1;
                            ph_d  = P_HI;
                        end else begin
                            div_d = div_q + 16'd1;
                        end
                    end
                    P_HI: begin
                        if (div_q == DIV_M1) begin
                            div_d = '0;
                            scl_d = 1'b0;
                            if (bitn_q != 3'd7) begin
                                bitn_d = bitn_q + 3'd1;
                                sh_d   = {sh_q[6:0], 1'b0};
                                sd_d   = sh_q[6];
                                ph_d   = P_LO;
                            end else begin
                                rs_d     = 1'b1;
                                byte_end = 1'b1;
                            end
                        end else begin
                            div_d = div_q + 16'd1;
                        end
                    end
                    P_WAIT: begin
                        take_pix = pfull_q;
                    end
                    P_TAIL: begin
                        if (div_q == DIV_M1) begin
                            div_d = '0;
                            cs_d  = 1'b1;
                            ph_d  = P_GAP;
                            cnt_d = '0;
                            if (state_q == S_STREAM) begin
                                state_d = S_WINDOW;
                                idx_d   = IDX_WIN;
                                pcnt_d  = '0;
                                gsel_d  = G_N;
                            end else begin
                                idx_d  = idx_q + 5'd1;
                                gsel_d = ctl[1:0];
                            end
                        end else begin
                            div_d = div_q + 16'd1;
                        end
                    end
                    default: ph_d = P_GAP;
                endcase
            end
        endcase

        if (byte_end) begin
            if (state_q == S_STREAM) begin
                if (lopend_q) begin
                    ld       = 1'b1;
                    ld_byte  = lo_q;
                    lopend_d = 1'b0;
                end else if (pfull_q) begin
                    take_pix = 1'b1;
                end else if (pcnt_q == NPIX_C) begin
                    ph_d = P_TAIL;
                end else begin
                    ph_d = P_WAIT;
                end
            end else if (ctl[2]) begin
                ph_d = P_TAIL;
            end else begin
                idx_d   = idx_q + 5'd1;
                ld      = 1'b1;
                ld_byte = rom_byte(idx_q + 5'd1);
            end
        end

        if (take_pix) begin
            ld       = 1'b1;
            ld_byte  = pbuf_q[15:8];
            lo_d     = pbuf_q[7:0];
            lopend_d = 1'b1;
            pfull_d  = 1'b0;
        end

        if (start) begin
            ld      = 1'b1;
            ld_byte = rom_byte(idx_q);
            ld_rs   = ctl[3];
            cs_d    = 1'b0;
            if (idx_q == IDX_RAMWR) begin
                state_d = S_STREAM;
            end
        end

        if (ld) begin
            sh_d   = ld_byte;
            sd_d   = ld_byte[7];
            rs_d   = ld_rs;
            bitn_d = '0;
            div_d  = '0;
            scl_d  = 1'b0;
            ph_d   = P_LO;
        end
    end

    // State and pin registers; reset forces the pins idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_START;
            ph_q     <= P_GAP;
            cnt_q    <= '0;
            div_q    <= '0;
            bitn_q   <= '0;
            sh_q     <= '0;
            idx_q    <= '0;
            gsel_q   <= G_N;
            pbuf_q   <= '0;
            pfull_q  <= 1'b0;
            lo_q     <= '0;
            lopend_q <= 1'b0;
            pcnt_q   <= '0;
            scl_q    <= 1'b0;
            cs_q     <= 1'b1;
            sd_q     <= 1'b0;
            rs_q     <= 1'b1;
            lrst_q   <= 1'b1;
            idone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bitn_q   <= bitn_d;
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            gsel_q   <= gsel_d;
            pbuf_q   <= pbuf_d;
            pfull_q  <= pfull_d;
            lo_q     <= lo_d;
            lopend_q <= lopend_d;
            pcnt_q   <= pcnt_d;
            scl_q    <= scl_d;
            cs_q     <= cs_d;
            sd_q     <= sd_d;
            rs_q     <= rs_d;
            lrst_q   <= lrst_d;
            idone_q  <= idone_d;
        end
    end

endmodule

// File: tb/tb_lcd_spi_panel_driver.sv
// Bench for lcd_spi_panel_driver: SPI byte monitor against an expected
// byte queue, plus power-up, underflow and mid-frame reset checks.
module tb_lcd_spi_panel_driver;

    logic        clk;
    logic        rst;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_start;
    logic        init_done;
    logic        lcd_rst;
    logic        lcd_rs;
    logic        lcd_sd;
    logic        lcd_scl;
    logic        lcd_cs;

    lcd_spi_panel_driver #(
        .CLK_DIV(2), .DISP_W(4), .DISP_H(2),
        .COL_OFS(52), .ROW_OFS(40),
        .START_DLY(8), .HWRST_DLY(4),
        .LONG_DLY(20), .SHORT_DLY(6), .INVERT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_start(frame_start),
        .init_done(init_done), .lcd_rst(lcd_rst),
        .lcd_rs(lcd_rs), .lcd_sd(lcd_sd),
        .lcd_scl(lcd_scl), .lcd_cs(lcd_cs)
    );

    typedef struct {
        int         gmin;
        bit         first;
        bit         rs;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cs_rise_cyc = 0;

    logic [15:0] pix [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                             16'h0000, 16'h1234, 16'hABCD, 16'h8001};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic push(input int g, input bit f, input bit r,
                        input logic [7:0] b);
        exp_t e;
        e.gmin = g; e.first = f; e.rs = r; e.b = b;
        q.push_back(e);
    endtask

    task automatic push_init();
        push(0, 1, 0, 8'h01);
        push(20, 1, 0, 8'h11);
        push(20, 1, 0, 8'h3A); push(0, 0, 1, 8'h55);
        push(6, 1, 0, 8'h36);  push(0, 0, 1, 8'h00);
        push(4, 1, 0, 8'h21);
        push(6, 1, 0, 8'h13);
        push(6, 1, 0, 8'h29);
    endtask

    task automatic push_window(input int g);
        push(g, 1, 0, 8'h2A);
        push(0, 0, 1, 8'h00); push(0, 0, 1, 8'h34);
        push(0, 0, 1, 8'h00); push(0, 0, 1, 8'h37);
        push(4, 1, 0, 8'h2B);
        push(0, 0, 1, 8'h00); push(0, 0, 1, 8'h28);
        push(0, 0, 1, 8'h00); push(0, 0, 1, 8'h29);
        push(4, 1, 0, 8'h2C);
    endtask

    task automatic chk_reset_vals();
        chk("rst_lcd_rst", lcd_rst, 1);
        chk("rst_lcd_cs", lcd_cs, 1);
        chk("rst_lcd_scl", lcd_scl, 0);
        chk("rst_lcd_sd", lcd_sd, 0);
        chk("rst_lcd_rs", lcd_rs, 1);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_init_done", init_done, 0);
    endtask

    // Release reset and time the START / HWRST / POSTRST phases.
    task automatic powerup();
        int n;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (lcd_rst && n < 1000) begin n++; @(negedge clk); end
        chk("start_delay", n, 8);
        n = 0;
        while (!lcd_rst && n < 1000) begin n++; @(negedge clk); end
        chk("hwrst_width", n, 4);
        n = 0;
        while (lcd_cs && n < 1000) begin n++; @(negedge clk); end
        chk("postrst_delay", n, 20);
    endtask

    task automatic send_pix(input logic [15:0] d, input bit first);
        int n;
        pix_data = d;
        pix_valid = 1'b1;
        #1;
        n = 0;
        while (!pix_ready && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        if (!pix_ready) begin
            fail("pix_handshake");
            return;
        end
        chk("frame_start", frame_start, first);
        push(0, 0, 1, d[15:8]);
        push(0, 0, 1, d[7:0]);
        @(negedge clk);
    endtask

    task automatic wait_init_done();
        int n;
        n = 0;
        while (!init_done && n < 5000) begin @(negedge clk); n++; end
        if (!init_done) fail("init_done");
        else chk("init_done_delay", cyc - cs_rise_cyc, 20);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
        if (q.size() != 0) fail(nm);
    endtask

    // SPI monitor: rebuild bytes on SCL rises and score them in order.
    int         nb = 0;
    int         gap = 0;
    bit         new_txn = 1;
    bit         rsbad = 0;
    logic       rs0 = 1'b0;
    logic       prev_scl = 1'b0;
    logic       prev_cs = 1'b1;
    logic [7:0] msh = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            nb = 0; gap = 0; new_txn = 1;
            prev_scl = 1'b0; prev_cs = 1'b1;
        end else begin
            if (lcd_cs && !prev_cs) cs_rise_cyc = cyc;
            if (lcd_cs) begin
                gap++;
                new_txn = 1;
                nb = 0;
            end else if (lcd_scl && !prev_scl) begin
                if (nb == 0) begin
                    rs0 = lcd_rs;
                    rsbad = 0;
                end else if (lcd_rs !== rs0) begin
                    rsbad = 1;
                end
                msh = {msh[6:0], lcd_sd};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spi_byte: got unexpected %0h", msh);
                    end else begin
                        e = q.pop_front();
                        chk("spi_byte", {22'd0, new_txn, rs0, msh},
                            {22'd0, e.first, e.rs, e.b});
                        chk("spi_rs_stable", {31'd0, rsbad}, 0);
                        if (new_txn) begin
                            checks++;
                            if (gap < e.gmin) begin
                                errors++;
                                $display("FAIL cs_gap: got %0d need >= %0d",
                                         gap, e.gmin);
                            end
                        end
                    end
                    if (new_txn) gap = 0;
                    new_txn = 0;
                end
            end
            prev_scl = lcd_scl;
            prev_cs = lcd_cs;
        end
    end

    initial begin
        int bad;
        rst = 1'b0;
        pix_valid = 1'b0;
        pix_data = 16'h0000;
        repeat (3) @(negedge clk);
        chk_reset_vals();

        push_init();
        push_window(20);
        powerup();
        wait_init_done();

        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                pix_valid = 1'b0;
                repeat (170) @(negedge clk);
                bad = 0;
                for (int k = 0; k < 50; k++) begin
                    if (lcd_scl !== 1'b0 || lcd_cs !== 1'b0) bad++;
                    @(negedge clk);
                end
                chk("underflow_idle", bad, 0);
            end
            send_pix(pix[i], i == 0);
        end
        pix_valid = 1'b0;
        push_window(4);
        wait_drain("frame1_drain");

        for (int i = 0; i < 5; i++) begin
            send_pix(pix[i], i == 0);
        end
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals();
        pix_valid = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);

        push_init();
        push_window(20);
        powerup();
        wait_init_done();
        wait_drain("reinit_drain");
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
